// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 constants: register numbers, Status/Cause bit positions,
// exception codes and the field masks applied to mtc0 writes.
package cp0_regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 32;
    localparam int EXC_CODE_W = 5;

    localparam logic [REG_ADDR_W-1:0] CP0_BADVADDR = 5'd8;
    localparam logic [REG_ADDR_W-1:0] CP0_COUNT    = 5'd9;
    localparam logic [REG_ADDR_W-1:0] CP0_COMPARE  = 5'd11;
    localparam logic [REG_ADDR_W-1:0] CP0_STATUS   = 5'd12;
    localparam logic [REG_ADDR_W-1:0] CP0_CAUSE    = 5'd13;
    localparam logic [REG_ADDR_W-1:0] CP0_EPC      = 5'd14;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int CAUSE_BD   = 31;

    localparam logic [EXC_CODE_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_CODE_W-1:0] EXC_ADES = 5'd5;
    localparam logic [EXC_CODE_W-1:0] EXC_OV   = 5'd12;

    localparam logic [WORD_W-1:0] STATUS_RST_DEFAULT = 32'h0040_0000;
    localparam logic [WORD_W-1:0] STATUS_WMASK       = 32'h0000_FF03;

    function automatic logic [WORD_W-1:0] masked_write(input logic [WORD_W-1:0] old_val,
                                                       input logic [WORD_W-1:0] new_val,
                                                       input logic [WORD_W-1:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances once every 2**COUNT_DIV_LOG2 cycles and
// timer_irq latches on a Count==Compare match until Compare is rewritten.
module cp0_timer
    import cp0_regfile_pkg::*;
#(
    parameter int COUNT_DIV_LOG2 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              count_we,
    input  logic              compare_we,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] count,
    output logic [WORD_W-1:0] compare,
    output logic              timer_irq
);

    localparam int DIV_W = (COUNT_DIV_LOG2 > 0) ? COUNT_DIV_LOG2 : 1;

    logic [DIV_W-1:0]  div;
    logic              tick;
    logic [WORD_W-1:0] count_next;

    assign tick = (COUNT_DIV_LOG2 == 0) || (&div);

    always_comb begin
        count_next = count;
        if (count_we)
            count_next = wdata;
        else if (tick)
            count_next = count + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div       <= '0;
            count     <= '0;
            compare   <= '0;
            timer_irq <= 1'b0;
        end else begin
            count <= count_next;
            div   <= count_we ? '0 : div + 1'b1;
            // Rewriting Compare acknowledges the interrupt, even against a fresh match.
            if (compare_we) begin
                compare   <= wdata;
                timer_irq <= 1'b0;
            end else if (count_next == compare && compare != '0) begin
                timer_irq <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: combinational reads, mtc0 commit, exception/eret recording
// and interrupt request. Define CP0_TIMER_EN to make Count/Compare a running timer.
module cp0_regfile
    import cp0_regfile_pkg::*;
#(
    parameter int                COUNT_DIV_LOG2 = 1,
    parameter logic [WORD_W-1:0] STATUS_RST     = STATUS_RST_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  re,
    input  logic [REG_ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0]     rdata,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0]     wdata,
    input  logic                  exc_valid,
    input  logic [EXC_CODE_W-1:0] exc_code,
    input  logic [WORD_W-1:0]     exc_pc,
    input  logic                  exc_bd,
    input  logic [WORD_W-1:0]     exc_badvaddr,
    input  logic                  eret,
    input  logic [5:0]            int_i,
    output logic [WORD_W-1:0]     status_o,
    output logic [WORD_W-1:0]     cause_o,
    output logic [WORD_W-1:0]     epc_o,
    output logic                  int_req_o
);

    logic [WORD_W-1:0] badvaddr, status, cause, epc, count, compare;
    logic              timer_irq;
    logic              wr_ok;

    // exc_valid and eret both outrank an mtc0 in the same cycle.
    assign wr_ok = we & ~exc_valid & ~eret;

`ifdef CP0_TIMER_EN
    cp0_timer #(.COUNT_DIV_LOG2(COUNT_DIV_LOG2)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (wr_ok && waddr == CP0_COUNT),
        .compare_we (wr_ok && waddr == CP0_COMPARE),
        .wdata      (wdata),
        .count      (count),
        .compare    (compare),
        .timer_irq  (timer_irq)
    );
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            compare <= '0;
        end else if (wr_ok) begin
            if (waddr == CP0_COUNT)   count   <= wdata;
            if (waddr == CP0_COMPARE) compare <= wdata;
        end
    end

    assign timer_irq = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            badvaddr  <= '0;
            status    <= STATUS_RST;
            cause     <= '0;
            epc       <= '0;
            int_req_o <= 1'b0;
        end else begin
            cause[15:10] <= {int_i[5] | timer_irq, int_i[4:0]};
            int_req_o    <= status[STATUS_IE] & ~status[STATUS_EXL] & (|(cause[15:8] & status[15:8]));
            if (exc_valid) begin
                cause[6:2] <= exc_code;
                // A nested exception keeps the original return point.
                if (!status[STATUS_EXL]) begin
                    epc             <= exc_bd ? exc_pc - 32'd4 : exc_pc;
                    cause[CAUSE_BD] <= exc_bd;
                end
                status[STATUS_EXL] <= 1'b1;
                if (exc_code == EXC_ADEL || exc_code == EXC_ADES)
                    badvaddr <= exc_badvaddr;
            end else if (eret) begin
                status[STATUS_EXL] <= 1'b0;
            end else if (we) begin
                case (waddr)
                    CP0_STATUS: status     <= masked_write(status, wdata, STATUS_WMASK);
                    CP0_CAUSE:  cause[9:8] <= wdata[9:8];
                    CP0_EPC:    epc        <= wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (re) begin
            case (raddr)
                CP0_BADVADDR: rdata = badvaddr;
                CP0_COUNT:    rdata = count;
                CP0_COMPARE:  rdata = compare;
                CP0_STATUS:   rdata = status;
                CP0_CAUSE:    rdata = cause;
                CP0_EPC:      rdata = epc;
                default:      rdata = '0;
            endcase
        end
    end

    assign status_o = status;
    assign cause_o  = cause;
    assign epc_o    = epc;

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: expectations are queued with each stimulus
// and compared after the clock edge that should produce them.
module tb_cp0_regfile;
    import cp0_regfile_pkg::*;

    logic        clk, rst, re, we, exc_valid, exc_bd, eret, int_req_o;
    logic [4:0]  raddr, waddr, exc_code;
    logic [31:0] rdata, wdata, exc_pc, exc_badvaddr, status_o, cause_o, epc_o;
    logic [5:0]  int_i;

    typedef struct {
        string       tag;
        bit          is_irq;
        bit          rd_en;
        logic [4:0]  addr;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    cp0_regfile #(.COUNT_DIV_LOG2(1), .STATUS_RST(32'h0040_0000)) dut (
        .clk(clk), .rst(rst), .re(re), .raddr(raddr), .rdata(rdata),
        .we(we), .waddr(waddr), .wdata(wdata),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
        .exc_badvaddr(exc_badvaddr), .eret(eret), .int_i(int_i),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .int_req_o(int_req_o)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_rd(input string tag, input logic [4:0] a, input logic [31:0] v);
        sb.push_back('{tag, 1'b0, 1'b1, a, v});
    endtask

    task automatic push_nore(input string tag, input logic [4:0] a);
        sb.push_back('{tag, 1'b0, 1'b0, a, 32'h0});
    endtask

    task automatic push_irq(input string tag, input logic v);
        sb.push_back('{tag, 1'b1, 1'b0, 5'd0, {31'b0, v}});
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.is_irq) begin
                #1;
                chk(e.tag, {31'b0, int_req_o}, e.val);
            end else begin
                re    = e.rd_en;
                raddr = e.addr;
                #1;
                chk(e.tag, rdata, e.val);
            end
        end
        re = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        waddr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                       input logic [31:0] bva);
        exc_valid = 1'b1; exc_code = code; exc_pc = pc; exc_bd = bd; exc_badvaddr = bva;
    endtask

    initial begin
        rst = 1'b1; re = 1'b0; raddr = '0; we = 1'b0; waddr = '0; wdata = '0;
        exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0; exc_badvaddr = '0;
        eret = 1'b0; int_i = '0;
        cyc(2);
        rst = 1'b0;

        // Reset values
        push_rd("rst_status", CP0_STATUS, 32'h0040_0000);
        push_rd("rst_epc", CP0_EPC, 32'h0);
        push_rd("rst_addr5", 5'd5, 32'h0);
        push_rd("rst_cause", CP0_CAUSE, 32'h0);
        push_irq("rst_irq", 1'b0);
        drain();

        // Status write and hardware interrupt path
        wr(CP0_STATUS, 32'h0000_FF01);
        push_rd("status_wr", CP0_STATUS, 32'h0040_FF01);
        drain();
        int_i = 6'b000001;
        cyc(1);
        push_rd("ip10_set", CP0_CAUSE, 32'h0000_0400);
        push_irq("irq_lag", 1'b0);
        drain();
        cyc(1);
        push_irq("irq_set", 1'b1);
        drain();
        int_i = 6'b0;
        cyc(2);
        push_rd("ip10_clr", CP0_CAUSE, 32'h0);
        push_irq("irq_clr", 1'b0);
        drain();

        // Software interrupt bits are the only writable Cause field
        wr(CP0_CAUSE, 32'hFFFF_FFFF);
        push_rd("cause_sw", CP0_CAUSE, 32'h0000_0300);
        drain();
        cyc(1);
        push_irq("irq_sw", 1'b1);
        drain();
        wr(CP0_CAUSE, 32'h0);
        cyc(1);
        push_irq("irq_sw_clr", 1'b0);
        drain();

        // Read-only / unmapped writes, re=0 reads
        wr(CP0_BADVADDR, 32'h1234_5678);
        wr(5'd5, 32'hFFFF_FFFF);
        push_rd("bva_ro", CP0_BADVADDR, 32'h0);
        push_rd("addr5_wr", 5'd5, 32'h0);
        push_nore("re_off", CP0_STATUS);
        drain();

        // A read in the write cycle shows the old value
        waddr = CP0_EPC; wdata = 32'h0000_1111; we = 1'b1;
        push_rd("epc_pre", CP0_EPC, 32'h0);
        drain();
        @(negedge clk);
        we = 1'b0;
        push_rd("epc_post", CP0_EPC, 32'h0000_1111);
        drain();

        // Exception in a delay slot beats a same-cycle mtc0
        exc(EXC_OV, 32'hBFC0_0100, 1'b1, 32'h0000_DEAD);
        waddr = CP0_EPC; wdata = 32'h5555_5555; we = 1'b1;
        @(negedge clk);
        exc_valid = 1'b0; we = 1'b0;
        push_rd("exc1_epc", CP0_EPC, 32'hBFC0_00FC);
        push_rd("exc1_cause", CP0_CAUSE, 32'h8000_0030);
        push_rd("exc1_status", CP0_STATUS, 32'h0040_FF03);
        push_rd("exc1_bva", CP0_BADVADDR, 32'h0);
        drain();

        // Nested exception: EPC/BD held, ExcCode and BadVAddr updated
        exc(EXC_ADEL, 32'h8000_0000, 1'b0, 32'hDEAD_BEEF);
        @(negedge clk);
        exc_valid = 1'b0;
        push_rd("exc2_epc", CP0_EPC, 32'hBFC0_00FC);
        push_rd("exc2_cause", CP0_CAUSE, 32'h8000_0010);
        push_rd("exc2_bva", CP0_BADVADDR, 32'hDEAD_BEEF);
        drain();

        // eret, and eret losing to exc_valid
        eret = 1'b1;
        @(negedge clk);
        eret = 1'b0;
        push_rd("eret_status", CP0_STATUS, 32'h0040_FF01);
        push_rd("eret_epc", CP0_EPC, 32'hBFC0_00FC);
        drain();
        eret = 1'b1;
        exc(EXC_ADES, 32'h0000_0100, 1'b0, 32'h0000_0044);
        @(negedge clk);
        eret = 1'b0; exc_valid = 1'b0;
        push_rd("exc_eret_status", CP0_STATUS, 32'h0040_FF03);
        push_rd("exc_eret_epc", CP0_EPC, 32'h0000_0100);
        push_rd("exc_eret_cause", CP0_CAUSE, 32'h0000_0014);
        push_rd("exc_eret_bva", CP0_BADVADDR, 32'h0000_0044);
        drain();

        // eret drops a same-cycle mtc0
        eret = 1'b1;
        waddr = CP0_STATUS; wdata = 32'h0; we = 1'b1;
        @(negedge clk);
        eret = 1'b0; we = 1'b0;
        push_rd("eret_we_status", CP0_STATUS, 32'h0040_FF01);
        drain();

`ifdef CP0_TIMER_EN
        wr(CP0_COMPARE, 32'd10);
        wr(CP0_COUNT, 32'd0);
        cyc(19);
        push_rd("tmr_count9", CP0_COUNT, 32'd9);
        push_rd("tmr_ip_pre", CP0_CAUSE, 32'h0000_0014);
        drain();
        cyc(1);
        push_rd("tmr_count10", CP0_COUNT, 32'd10);
        push_rd("tmr_ip_lag", CP0_CAUSE, 32'h0000_0014);
        drain();
        cyc(1);
        push_rd("tmr_ip15", CP0_CAUSE, 32'h0000_8014);
        push_irq("tmr_irq_lag", 1'b0);
        drain();
        cyc(1);
        push_irq("tmr_irq", 1'b1);
        drain();
        wr(CP0_COMPARE, 32'd50);
        push_rd("tmr_compare", CP0_COMPARE, 32'd50);
        drain();
        cyc(1);
        push_rd("tmr_ip_clr", CP0_CAUSE, 32'h0000_0014);
        drain();
        wr(CP0_COUNT, 32'hFFFF_FFFF);
        push_rd("tmr_max", CP0_COUNT, 32'hFFFF_FFFF);
        drain();
        cyc(1);
        push_rd("tmr_max_hold", CP0_COUNT, 32'hFFFF_FFFF);
        drain();
        cyc(1);
        push_rd("tmr_wrap", CP0_COUNT, 32'h0);
        drain();
`else
        wr(CP0_COUNT, 32'd5);
        wr(CP0_COMPARE, 32'd7);
        cyc(100);
        push_rd("cnt_held", CP0_COUNT, 32'd5);
        push_rd("cmp_held", CP0_COMPARE, 32'd7);
        drain();
        int_i = 6'b100000;
        cyc(1);
        push_rd("ip15_int5", CP0_CAUSE, 32'h0000_8014);
        drain();
        int_i = 6'b0;
        cyc(1);
        push_rd("ip15_clr", CP0_CAUSE, 32'h0000_0014);
        drain();
`endif

        // Asynchronous reset mid-operation
        @(negedge clk);
        #3 rst = 1'b1;
        push_rd("arst_status", CP0_STATUS, 32'h0040_0000);
        push_rd("arst_epc", CP0_EPC, 32'h0);
        push_rd("arst_cause", CP0_CAUSE, 32'h0);
        push_irq("arst_irq", 1'b0);
        drain();
        cyc(1);
        rst = 1'b0;
        cyc(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
